// File: rtl/wb_arb7.sv
// ============================================================================
// Module   : wb_arb7
// Brief    : 7-source round-robin bus arbiter with registered one-hot grant
//            and mux select. Optional hold-limit preemption is enabled by
//            defining WB_ARB7_HOLD_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arb7 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] req,
  output logic [6:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] c_hold_max = 4'(MAX_HOLD - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_owner;
  logic [2:0] r_ptr;
  logic [6:0] r_gnt;
  logic [2:0] w_win;
  logic       w_found;
  logic [3:0] w_sum;
  logic       w_load;
  logic       w_preempt_nxt;

  // Search starts just after the last owner, so that owner is considered last.
  always_comb begin : search
    w_win   = r_ptr;
    w_found = 1'b0;
    w_sum   = 4'd0;
    for (int k = 1; k <= 7; k++) begin
      w_sum = {1'b0, r_ptr} + 4'(k);
      if (w_sum >= 4'd7) w_sum = w_sum - 4'd7;
      if (!w_found && req[w_sum[2:0]]) begin
        w_win   = w_sum[2:0];
        w_found = 1'b1;
      end
    end
  end

`ifdef WB_ARB7_HOLD_LIMIT_EN
  logic [3:0] r_cnt;
  logic       r_preempt;
  logic       w_others;

  assign w_others = |(req & ~r_gnt);
`endif

  always_comb begin : next_state
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_preempt_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_GRANT;
          w_load      = 1'b1;
        end
      end
      ST_GRANT: begin
        // A release by the owner takes priority over the hold limit.
        if (!req[r_owner]) begin
          if (|req) w_load = 1'b1;
          else      w_state_nxt = ST_IDLE;
        end
`ifdef WB_ARB7_HOLD_LIMIT_EN
        else if ((r_cnt == c_hold_max) && w_others) begin
          w_load        = 1'b1;
          w_preempt_nxt = 1'b1;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= 3'd0;
      r_ptr   <= 3'd6;
      r_gnt   <= 7'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_owner <= w_win;
        r_ptr   <= w_win;
        r_gnt   <= 7'b1 << w_win;
      end else if (w_state_nxt == ST_IDLE) begin
        r_gnt   <= 7'd0;
      end
    end
  end

`ifdef WB_ARB7_HOLD_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= w_preempt_nxt;
      if (w_load)
        r_cnt <= 4'd0;
      else if ((r_state == ST_GRANT) && (r_cnt != c_hold_max))
        r_cnt <= r_cnt + 4'd1;
    end
  end

  assign preempt = r_preempt;
`else
  logic unused_hold;
  assign unused_hold = ^{c_hold_max, w_preempt_nxt};
  assign preempt     = 1'b0;
`endif

  assign gnt  = r_gnt;
  assign sel  = r_owner;
  assign busy = |r_gnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_arb7.sv
// ============================================================================
// Module   : tb_wb_arb7
// Brief    : Scoreboard bench for wb_arb7 (default build or hold-limit build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arb7;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] req = 7'd0;
  logic [6:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       preempt;

  always #5 clk = ~clk;

  wb_arb7 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  typedef struct packed {
    logic [6:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       pre;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   errors  = 0;
  int   m_busy, m_owner, m_ptr, m_cnt;

  function automatic exp_t observe();
    return {gnt, sel, busy, preempt};
  endfunction

  function automatic int rr_pick(int base, logic [6:0] r);
    for (int k = 1; k < 8; k++)
      if (r[(base + k) % 7]) return (base + k) % 7;
    return base;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 6; m_cnt = 0;
  endtask

  // Drive one request pattern, predict the post-edge outputs, advance one edge.
  task automatic drive(input logic [6:0] r);
    int         w;
    logic       pre;
    logic [6:0] oh;
    pre = 1'b0;
    req = r;
    if (m_busy == 0) begin
      if (r != 0) begin
        w = rr_pick(m_ptr, r); m_owner = w; m_ptr = w; m_busy = 1; m_cnt = 0;
      end
    end else if (!r[m_owner]) begin
      if (r == 0) m_busy = 0;
      else begin
        w = rr_pick(m_ptr, r); m_owner = w; m_ptr = w; m_cnt = 0;
      end
    end
`ifdef WB_ARB7_HOLD_LIMIT_EN
    else begin
      oh = 7'b1 << m_owner;
      if (m_cnt == MAX_HOLD - 1 && (r & ~oh) != 0) begin
        w = rr_pick(m_ptr, r); m_owner = w; m_ptr = w; m_cnt = 0; pre = 1'b1;
      end else if (m_cnt < MAX_HOLD - 1) begin
        m_cnt++;
      end
    end
`endif
    oh = (m_busy != 0) ? (7'b1 << m_owner) : 7'd0;
    sb.push_back('{gnt: oh, sel: 3'(m_owner), busy: (m_busy != 0), pre: pre});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 7'd0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sb.delete();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (observe() !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got %h expected 000", observe());
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(7'b0000001);
    e = sb.pop_front();
    vectors++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL first_grant: got %h expected %h", observe(), e);
    end
    vectors++;
    if (gnt !== 7'b0000001 || sel !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_grant_const: got gnt=%b sel=%0d busy=%b", gnt, sel, busy);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    drive(7'h7f);
    e = sb.pop_front();
    vectors++;
    if (observe() !== e || sel !== 3'd0) begin
      errors++;
      $display("FAIL rr_start: got %h expected %h", observe(), e);
    end
    for (int i = 0; i < 7; i++) begin
      drive(7'h7f);
      e = sb.pop_front();
      vectors++;
      if (observe() !== e) begin
        errors++;
        $display("FAIL rr_hold[%0d]: got %h expected %h", i, observe(), e);
      end
      drive(7'h7f & ~(7'b1 << i));
      e = sb.pop_front();
      vectors++;
      if (observe() !== e || sel !== 3'((i + 1) % 7) || busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_step[%0d]: got sel=%0d busy=%b expected sel=%0d busy=1",
                 i, sel, busy, (i + 1) % 7);
      end
    end
  endtask

  task automatic test_hold_limit();
    int pulses;
    int n;
    pulses = 0;
`ifdef WB_ARB7_HOLD_LIMIT_EN
    n = 9;
`else
    n = 20;
`endif
    apply_reset();
    drive(7'b0001000);
    e = sb.pop_front();
    vectors++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL hold_grant3: got %h expected %h", observe(), e);
    end
    for (int c = 1; c <= n; c++) begin
      drive(7'b0101000);
      if (preempt === 1'b1) pulses++;
      e = sb.pop_front();
      vectors++;
      if (observe() !== e) begin
        errors++;
        $display("FAIL hold[%0d]: got %h expected %h", c, observe(), e);
      end
    end
    vectors++;
`ifdef WB_ARB7_HOLD_LIMIT_EN
    if (pulses != 1 || gnt !== 7'b0100000) begin
      errors++;
      $display("FAIL hold_preempt: got pulses=%0d gnt=%b expected 1 0100000", pulses, gnt);
    end
`else
    if (pulses != 0 || gnt !== 7'b0001000) begin
      errors++;
      $display("FAIL hold_keep: got pulses=%0d gnt=%b expected 0 0001000", pulses, gnt);
    end
`endif
  endtask

  task automatic test_solo_wrap();
    int pulses;
    pulses = 0;
    apply_reset();
    drive(7'b1000000);
    e = sb.pop_front();
    vectors++;
    if (observe() !== e || gnt !== 7'b1000000) begin
      errors++;
      $display("FAIL solo_grant6: got %h expected %h", observe(), e);
    end
    for (int c = 0; c < 20; c++) begin
      drive(7'b1000000);
      if (preempt === 1'b1) pulses++;
      e = sb.pop_front();
      vectors++;
      if (observe() !== e) begin
        errors++;
        $display("FAIL solo[%0d]: got %h expected %h", c, observe(), e);
      end
    end
    vectors++;
    if (pulses != 0 || gnt !== 7'b1000000) begin
      errors++;
      $display("FAIL solo_keep: got pulses=%0d gnt=%b expected 0 1000000", pulses, gnt);
    end
`ifdef WB_ARB7_HOLD_LIMIT_EN
    drive(7'b1000001);
`else
    drive(7'b0000001);
`endif
    e = sb.pop_front();
    vectors++;
    if (observe() !== e || gnt !== 7'b0000001) begin
      errors++;
      $display("FAIL solo_wrap: got %h expected %h", observe(), e);
    end
  endtask

  task automatic test_reset_midgrant();
    apply_reset();
    drive(7'b0010000);
    drive(7'b0010000);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (observe() !== e && sb.size() == 0) begin
        errors++;
        $display("FAIL mid_pre: got %h expected %h", observe(), e);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (observe() !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got %h expected 000", observe());
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(7'b0010000);
    e = sb.pop_front();
    vectors++;
    if (observe() !== e || gnt !== 7'b0010000) begin
      errors++;
      $display("FAIL post_reset_grant: got %h expected %h", observe(), e);
    end
  endtask

  task automatic test_release_at_limit();
    apply_reset();
    drive(7'b0000100);
    e = sb.pop_front();
    vectors++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL lim_grant2: got %h expected %h", observe(), e);
    end
    for (int c = 1; c <= MAX_HOLD - 1; c++) begin
      drive(7'b0010100);
      e = sb.pop_front();
      vectors++;
      if (observe() !== e || gnt !== 7'b0000100) begin
        errors++;
        $display("FAIL lim_hold[%0d]: got %h expected %h", c, observe(), e);
      end
    end
    drive(7'b0010000);
    e = sb.pop_front();
    vectors++;
    if (observe() !== e || gnt !== 7'b0010000 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL lim_release: got gnt=%b pre=%b expected 0010000 0", gnt, preempt);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold_limit();
    test_solo_wrap();
    test_reset_midgrant();
    test_release_at_limit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/wb_arb7.md
WB_ARB7 -- requirements
Module: wb_arb7

Interface
REQ-001 Parameter MAX_HOLD, default 8, is the maximum number of consecutive grant cycles for one owner while another request is pending; legal range 2..15.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 REQ  input  7  request per source; bit i requests that source i drive the shared 16-bit bus through the 7:1 select mux.
REQ-005 GNT  output  7  one-hot grant, registered; all-zero when no owner.
REQ-006 SEL  output  3  select code for the 7:1 mux; equals the index of the set GNT bit; range 0..6 only.
REQ-007 BUSY  output  1  high while any GNT bit is set.
REQ-008 PREEMPT  output  1  one-cycle pulse on the edge where a grant is revoked by the hold limit.

Function
REQ-009 The block SHALL implement states IDLE and GRANT; the current owner index (0..6) SHALL be held in a 3-bit register that also drives SEL.
REQ-010 IDLE: if REQ is non-zero, the block SHALL enter GRANT on the next edge and grant the winner of the round-robin search; otherwise it stays in IDLE.
REQ-011 Grant latency SHALL be exactly one cycle from REQ sampled high to GNT high.
REQ-012 Round-robin search order SHALL be owner+1, owner+2, ... modulo 7 (6 wraps to 0); the previous owner is searched last.
REQ-013 GRANT: while REQ[owner] stays high, GNT SHALL remain unchanged, unless REQ-016 applies.
REQ-014 GRANT: when REQ[owner] is sampled low, the block SHALL re-arbitrate on that same edge; it grants the next requester with no idle cycle, or enters IDLE if REQ is all-zero.
REQ-015 A hold counter (4 bits) SHALL clear on every new grant and increment each GRANT cycle, saturating at MAX_HOLD-1.
REQ-016 When the counter equals MAX_HOLD-1 and REQ has any bit set other than the owner's, the block SHALL revoke on the next edge, grant the next requester per REQ-012, and pulse PREEMPT for one cycle.
REQ-017 At the hold limit with no other request pending, the owner SHALL keep the grant and the counter SHALL stay saturated.
REQ-018 Simultaneous drop of REQ[owner] and reaching the hold limit SHALL be treated as a normal release per REQ-014, with no PREEMPT.
REQ-019 In IDLE, SEL SHALL hold the last owner index and GNT SHALL be zero.
REQ-020 GNT SHALL never have more than one bit set, and SEL SHALL never equal 7.

Reset
REQ-021 RST_N low SHALL immediately force: state IDLE, GNT=0, SEL=0, BUSY=0, PREEMPT=0, hold counter 0, and priority pointer 6 so that source 0 searches first.
REQ-022 Reset asserted mid-grant SHALL drop the grant asynchronously; after release, the first grant SHALL follow REQ-010 one edge later.

Configuration
REQ-023 Macro WB_ARB7_HOLD_LIMIT_EN: when defined, the hold counter, REQ-015..REQ-018 and PREEMPT SHALL be implemented as specified.
REQ-024 Without WB_ARB7_HOLD_LIMIT_EN, the counter SHALL be omitted, an owner SHALL keep the grant until its REQ drops, and PREEMPT SHALL be tied to 0.

Verification
REQ-025 Reset release, then REQ=7'b0000001 -> next edge GNT=7'b0000001, SEL=0, BUSY=1.
REQ-026 REQ=7'b1111111 with each owner dropping after 2 cycles -> SEL sequence 0,1,2,3,4,5,6,0 with no idle cycle between grants.
REQ-027 Owner 3 holds REQ high, REQ[5] high, MAX_HOLD=8, macro defined -> GNT moves to 5 after 8 grant cycles, PREEMPT pulses once; without the macro -> GNT stays 3 indefinitely.
REQ-028 Owner 6 holds alone for 20 cycles with the macro defined -> no PREEMPT, GNT stays 7'b1000000; then REQ[0] rises -> GNT=7'b0000001 on the next edge (wrap-around).
REQ-029 RST_N pulled low mid-cycle during a grant to 4 -> GNT=0 and SEL=0 immediately (before the next CLK edge); after release with REQ=7'b0010000 -> GNT=7'b0010000 one edge later.
REQ-030 Owner 2 drops REQ on the same edge the hold limit is reached, with REQ[4] pending -> GNT=7'b0010000, PREEMPT stays 0.
